// File: rtl/datapath_pkg.sv
// Shared opcode and FSM-state encodings for param_datapath and its ALU.
// Pure declarations: no latency, no flow control.
// Consumers import with datapath_pkg::*.
package datapath_pkg;

    localparam logic [2:0] OP_MVI = 3'd0;
    localparam logic [2:0] OP_MV  = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_AND = 3'd5;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_MOVE  = 3'd1;
    localparam logic [2:0] S_LOADA = 3'd2;
    localparam logic [2:0] S_EXEC  = 3'd3;
    localparam logic [2:0] S_WRBK  = 3'd4;
    localparam logic [2:0] S_FIN   = 3'd5;

    function automatic logic is_alu_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_XOR) || (op == OP_AND);
    endfunction

endpackage

// File: rtl/param_datapath_alu.sv
// Combinational ALU for the A/G path: ADD, SUB, XOR, AND with zero/carry.
// Latency: none (pure combinational).
// Backpressure: none; the caller decides when to capture g and the flags.
module alu_unit
    import datapath_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   op,
    output logic [W-1:0] g,
    output logic         zero,
    output logic         carry
);

    logic [W:0] sum;

    always_comb begin
        sum   = '0;
        g     = '0;
        carry = 1'b0;
        case (op)
            OP_ADD: begin
                sum   = {1'b0, a} + {1'b0, b};
                g     = sum[W-1:0];
                carry = sum[W];
            end
            // Two's-complement subtract: carry-out set means no borrow (a >= b).
            OP_SUB: begin
                sum   = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
                g     = sum[W-1:0];
                carry = sum[W];
            end
            OP_XOR:  g = a ^ b;
            OP_AND:  g = a & b;
            default: g = '0;
        endcase
        zero = (g == '0);
    end

endmodule

// File: rtl/param_datapath.sv
// NREG x W register file with a shared A/G ALU path sequenced by a start/done FSM.
// Latency: start edge to done high is 2 cycles for MVI/MV/NOP and 4 cycles for ALU ops.
// Backpressure: start is sampled only in IDLE; requests while busy are dropped, not queued.
module param_datapath
    import datapath_pkg::*;
#(
    parameter int W      = 16,
    parameter int NREG   = 8,
    parameter int RSEL_W = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [RSEL_W-1:0] rx_sel,
    input  logic [RSEL_W-1:0] ry_sel,
    input  logic [W-1:0]      data_in,
    input  logic [RSEL_W-1:0] rd_sel,
    output logic [W-1:0]      rd_data,
    output logic              busy,
    output logic              done,
    output logic              zero_flag,
    output logic              carry_flag
);

    logic [2:0]        state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [RSEL_W-1:0] rx_q, rx_d;
    logic [RSEL_W-1:0] ry_q, ry_d;
    logic [W-1:0]      imm_q, imm_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      g_q, g_d;
    logic              zero_q, zero_d;
    logic              carry_q, carry_d;
    logic              done_q, done_d;
    logic [W-1:0]      regs_q [NREG];
    logic [W-1:0]      regs_d [NREG];

    logic              wr_en;
    logic [W-1:0]      wr_dat;
    logic [W-1:0]      alu_g;
    logic              alu_zero;
    logic              alu_carry;

    // Out-of-range selects (non-power-of-2 NREG) read as zero.
    function automatic logic [W-1:0] rd_reg(input logic [RSEL_W-1:0] s);
        return (int'(s) < NREG) ? regs_q[s] : '0;
    endfunction

    alu_unit #(.W(W)) u_alu (
        .a     (a_q),
        .b     (rd_reg(ry_q)),
        .op    (op_q),
        .g     (alu_g),
        .zero  (alu_zero),
        .carry (alu_carry)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rx_d    = rx_q;
        ry_d    = ry_q;
        imm_d   = imm_q;
        a_d     = a_q;
        g_d     = g_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        done_d  = (state_q == S_FIN);
        wr_en   = 1'b0;
        wr_dat  = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d = op;
                    rx_d = rx_sel;
                    ry_d = ry_sel;
                    if (op == OP_MVI) begin
                        imm_d = data_in;
                    end
                    state_d = is_alu_op(op) ? S_LOADA : S_MOVE;
                end
            end
            S_MOVE: begin
                wr_en   = (op_q == OP_MVI) || (op_q == OP_MV);
                wr_dat  = (op_q == OP_MVI) ? imm_q : rd_reg(ry_q);
                state_d = S_FIN;
            end
            S_LOADA: begin
                a_d     = rd_reg(rx_q);
                state_d = S_EXEC;
            end
            S_EXEC: begin
                g_d     = alu_g;
                zero_d  = alu_zero;
                carry_d = alu_carry;
                state_d = S_WRBK;
            end
            S_WRBK: begin
                wr_en   = 1'b1;
                wr_dat  = g_q;
                state_d = S_FIN;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Writes to a select >= NREG match no entry and are dropped.
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = (wr_en && (int'(rx_q) == i)) ? wr_dat : regs_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            rx_q    <= '0;
            ry_q    <= '0;
            imm_q   <= '0;
            a_q     <= '0;
            g_q     <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rx_q    <= rx_d;
            ry_q    <= ry_d;
            imm_q   <= imm_d;
            a_q     <= a_d;
            g_q     <= g_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            done_q  <= done_d;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign rd_data    = rd_reg(rd_sel);
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign zero_flag  = zero_q;
    assign carry_flag = carry_q;

endmodule

// File: tb/tb_param_datapath.sv
// Randomized and directed bench for param_datapath (W=16, NREG=8) against an arithmetic reference model.
module tb_param_datapath;

    localparam int W    = 16;
    localparam int NREG = 8;

    localparam logic [2:0] T_MVI = 3'd0;
    localparam logic [2:0] T_MV  = 3'd1;
    localparam logic [2:0] T_ADD = 3'd2;
    localparam logic [2:0] T_SUB = 3'd3;
    localparam logic [2:0] T_XOR = 3'd4;
    localparam logic [2:0] T_AND = 3'd5;
    localparam logic [2:0] T_NOP = 3'd6;

    logic          clk;
    logic          reset;
    logic          start;
    logic [2:0]    op;
    logic [2:0]    rx_sel;
    logic [2:0]    ry_sel;
    logic [W-1:0]  data_in;
    logic [2:0]    rd_sel;
    logic [W-1:0]  rd_data;
    logic          busy;
    logic          done;
    logic          zero_flag;
    logic          carry_flag;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] m_reg [NREG];
    logic         m_zero;
    logic         m_carry;

    param_datapath #(.W(W), .NREG(NREG)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .rx_sel     (rx_sel),
        .ry_sel     (ry_sel),
        .data_in    (data_in),
        .rd_sel     (rd_sel),
        .rd_data    (rd_data),
        .busy       (busy),
        .done       (done),
        .zero_flag  (zero_flag),
        .carry_flag (carry_flag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit is_alu(input logic [2:0] o);
        return (o >= T_ADD) && (o <= T_AND);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NREG; i++) m_reg[i] = '0;
        m_zero  = 1'b0;
        m_carry = 1'b0;
    endtask

    // Reference semantics straight from the operation definitions.
    task automatic model_exec(input logic [2:0] o, input int rx, input int ry, input logic [W-1:0] imm);
        int           s;
        logic [W-1:0] res;
        case (o)
            T_MVI: m_reg[rx] = imm;
            T_MV:  m_reg[rx] = m_reg[ry];
            T_ADD: begin
                s       = int'(m_reg[rx]) + int'(m_reg[ry]);
                res     = W'(s);
                m_carry = (s >= (1 << W));
            end
            T_SUB: begin
                s       = int'(m_reg[rx]) - int'(m_reg[ry]);
                res     = W'(s);
                m_carry = (m_reg[rx] >= m_reg[ry]);
            end
            T_XOR: begin res = m_reg[rx] ^ m_reg[ry]; m_carry = 1'b0; end
            T_AND: begin res = m_reg[rx] & m_reg[ry]; m_carry = 1'b0; end
            default: ;
        endcase
        if (is_alu(o)) begin
            m_zero    = (res == '0);
            m_reg[rx] = res;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        model_clear();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Issues one request, scrambles the inputs after the start edge, and measures latency and busy cycles.
    task automatic run_op(input logic [2:0] o, input int rx, input int ry, input logic [W-1:0] imm,
                          output int lat, output int busy_cnt);
        @(negedge clk);
        start   = 1'b1;
        op      = o;
        rx_sel  = 3'(rx);
        ry_sel  = 3'(ry);
        data_in = imm;
        @(posedge clk);
        #1;
        start   = 1'b0;
        op      = 3'($urandom);
        rx_sel  = 3'($urandom);
        ry_sel  = 3'($urandom);
        data_in = W'($urandom);
        model_exec(o, rx, ry, imm);
        lat      = 0;
        busy_cnt = busy ? 1 : 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = c;
                break;
            end
            if (busy) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        start   = 1'b0;
        op      = '0;
        rx_sel  = '0;
        ry_sel  = '0;
        data_in = '0;
        rd_sel  = '0;
        repeat (3) @(posedge clk);
        #1;
        model_clear();
        n_checks++;
        if ({busy, done, zero_flag, carry_flag} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy/done/zero/carry=%b required 0000", {busy, done, zero_flag, carry_flag});
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            rd_sel = 3'(i);
            #1;
            n_checks++;
            if (rd_data !== '0) begin
                n_fail++;
                $display("FAIL reset_reg R%0d: got %h required 0000", i, rd_data);
            end
        end
    endtask

    task automatic test_mvi();
        int lat, bc;
        run_op(T_MVI, 3, 0, 16'h1234, lat, bc);
        n_checks++;
        if (lat !== 2 || bc !== 2) begin
            n_fail++;
            $display("FAIL mvi_timing: latency %0d busy %0d required 2 and 2", lat, bc);
        end
        rd_sel = 3'd3;
        #1;
        n_checks++;
        if (rd_data !== 16'h1234) begin
            n_fail++;
            $display("FAIL mvi_data: R3=%h required 1234", rd_data);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_width: done=%b on second cycle required 0", done);
        end
    endtask

    task automatic test_add();
        int lat, bc;
        run_op(T_MVI, 1, 0, 16'hFFFF, lat, bc);
        run_op(T_MVI, 2, 0, 16'h0001, lat, bc);
        run_op(T_ADD, 1, 2, '0, lat, bc);
        rd_sel = 3'd1;
        #1;
        n_checks++;
        if (lat !== 4 || bc !== 4) begin
            n_fail++;
            $display("FAIL add_timing: latency %0d busy %0d required 4 and 4", lat, bc);
        end
        n_checks++;
        if (rd_data !== m_reg[1] || zero_flag !== m_zero || carry_flag !== m_carry) begin
            n_fail++;
            $display("FAIL add_wrap: R1=%h z=%b c=%b required %h z=%b c=%b",
                     rd_data, zero_flag, carry_flag, m_reg[1], m_zero, m_carry);
        end
    endtask

    task automatic test_sub();
        int lat, bc;
        run_op(T_MVI, 4, 0, 16'd5, lat, bc);
        run_op(T_MVI, 5, 0, 16'd7, lat, bc);
        run_op(T_SUB, 4, 5, '0, lat, bc);
        rd_sel = 3'd4;
        #1;
        n_checks++;
        if (rd_data !== 16'hFFFE || zero_flag !== 1'b0 || carry_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_borrow: R4=%h z=%b c=%b required fffe z=0 c=0", rd_data, zero_flag, carry_flag);
        end
        run_op(T_SUB, 5, 5, '0, lat, bc);
        rd_sel = 3'd5;
        #1;
        n_checks++;
        if (rd_data !== 16'h0000 || zero_flag !== 1'b1 || carry_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL sub_self: R5=%h z=%b c=%b required 0000 z=1 c=1", rd_data, zero_flag, carry_flag);
        end
    endtask

    task automatic test_xor_mv();
        int lat, bc;
        run_op(T_MVI, 6, 0, 16'hF0F0, lat, bc);
        run_op(T_MVI, 7, 0, 16'h5A5A, lat, bc);
        run_op(T_XOR, 6, 6, '0, lat, bc);
        rd_sel = 3'd6;
        #1;
        n_checks++;
        if (rd_data !== 16'h0000 || zero_flag !== 1'b1 || carry_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL xor_self: R6=%h z=%b c=%b required 0000 z=1 c=0", rd_data, zero_flag, carry_flag);
        end
        run_op(T_MV, 7, 6, '0, lat, bc);
        rd_sel = 3'd7;
        #1;
        n_checks++;
        if (rd_data !== 16'h0000 || lat !== 2 || zero_flag !== 1'b1 || carry_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL mv_copy: R7=%h lat=%0d z=%b c=%b required 0000 lat=2 z=1 c=0",
                     rd_data, lat, zero_flag, carry_flag);
        end
    endtask

    task automatic test_start_held();
        int  lat, bc, got, dones;
        bit  busy_after;
        run_op(T_MVI, 1, 0, 16'd10, lat, bc);
        run_op(T_MVI, 2, 0, 16'd20, lat, bc);
        run_op(T_MVI, 3, 0, 16'h0033, lat, bc);
        @(negedge clk);
        start  = 1'b1;
        op     = T_ADD;
        rx_sel = 3'd1;
        ry_sel = 3'd2;
        @(posedge clk);
        #1;
        model_exec(T_ADD, 1, 2, '0);
        op      = T_MVI;
        rx_sel  = 3'd3;
        data_in = 16'hBEEF;
        got   = 0;
        dones = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                got = c;
                dones++;
                start = 1'b0;
                break;
            end
        end
        start      = 1'b0;
        busy_after = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done) dones++;
            if (busy) busy_after = 1'b1;
        end
        n_checks++;
        if (got !== 4 || dones !== 1 || busy_after !== 1'b0) begin
            n_fail++;
            $display("FAIL start_held: latency %0d dones %0d busy_after %b required 4, 1, 0", got, dones, busy_after);
        end
        rd_sel = 3'd1;
        #1;
        n_checks++;
        if (rd_data !== m_reg[1]) begin
            n_fail++;
            $display("FAIL start_held_r1: R1=%h required %h", rd_data, m_reg[1]);
        end
        rd_sel = 3'd3;
        #1;
        n_checks++;
        if (rd_data !== m_reg[3]) begin
            n_fail++;
            $display("FAIL start_held_r3: R3=%h required %h", rd_data, m_reg[3]);
        end
    endtask

    task automatic test_reset_mid();
        int  lat, bc;
        bit  saw_done;
        run_op(T_MVI, 0, 0, 16'd3, lat, bc);
        run_op(T_MVI, 1, 0, 16'd4, lat, bc);
        @(negedge clk);
        start  = 1'b1;
        op     = T_ADD;
        rx_sel = 3'd0;
        ry_sel = 3'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        model_clear();
        rd_sel = 3'd0;
        #1;
        n_checks++;
        if (rd_data !== 16'h0000 || done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: R0=%h done=%b busy=%b required 0000 0 0", rd_data, done, busy);
        end
        @(negedge clk);
        reset    = 1'b0;
        saw_done = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (done || busy) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_quiet: activity after reset=%b required 0", saw_done);
        end
        run_op(T_MVI, 2, 0, 16'hABCD, lat, bc);
        run_op(T_NOP, 2, 2, 16'h1111, lat, bc);
        rd_sel = 3'd2;
        #1;
        n_checks++;
        if (lat !== 2 || rd_data !== m_reg[2]) begin
            n_fail++;
            $display("FAIL nop: latency %0d R2=%h required 2 and %h", lat, rd_data, m_reg[2]);
        end
    endtask

    task automatic test_random();
        int           lat, bc, rx, ry, exp_lat;
        logic [2:0]   o;
        logic [W-1:0] imm;
        for (int n = 0; n < 60; n++) begin
            o   = 3'($urandom_range(0, 7));
            if (n < 8) o = T_MVI;
            rx  = $urandom_range(0, NREG - 1);
            ry  = $urandom_range(0, NREG - 1);
            imm = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 2)) : W'($urandom);
            exp_lat = is_alu(o) ? 4 : 2;
            run_op(o, rx, ry, imm, lat, bc);
            n_checks++;
            if (lat !== exp_lat || bc !== exp_lat || zero_flag !== m_zero || carry_flag !== m_carry) begin
                n_fail++;
                $display("FAIL rand_ctrl #%0d op%0d: lat=%0d busy=%0d z=%b c=%b required lat=%0d busy=%0d z=%b c=%b",
                         n, o, lat, bc, zero_flag, carry_flag, exp_lat, exp_lat, m_zero, m_carry);
            end
            for (int i = 0; i < NREG; i++) begin
                rd_sel = 3'(i);
                #1;
                n_checks++;
                if (rd_data !== m_reg[i]) begin
                    n_fail++;
                    $display("FAIL rand_reg #%0d op%0d R%0d: got %h required %h", n, o, i, rd_data, m_reg[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_mvi();
        test_add();
        test_sub();
        test_xor_mv();
        test_start_held();
        test_reset_mid();
        do_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
